// File: rtl/mvm_stream_driver_pkg.sv
// Shared parameters and types for the MVM stream driver: flit widths,
// driver state encoding and the program-memory entry layout.
package mvm_stream_driver_pkg;

  localparam int PKG_TDATAW = 512;
  localparam int PKG_TDESTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } drv_state_t;

  typedef struct packed {
    logic                  last;
    logic [PKG_TDESTW-1:0] dest;
    logic [PKG_TDATAW-1:0] data;
  } prog_entry_t;

endpackage

// File: rtl/mvm_prog_ram.sv
// Simple dual-port program memory: one write port, one registered read port
// with a single cycle of read latency. Contents are never reset.
module mvm_prog_ram
  import mvm_stream_driver_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  prog_entry_t     wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output prog_entry_t     rd_data
);

  prog_entry_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/mvm_stream_driver.sv
// Streams a preloaded flit program into a NoC injection port, then counts
// returned result flits and flags completion or timeout.
module mvm_stream_driver
  import mvm_stream_driver_pkg::*;
#(
  parameter int TDATAW     = PKG_TDATAW,
  parameter int TDESTW     = PKG_TDESTW,
  parameter int PROG_DEPTH = 64,
  parameter int CNTW       = 16,
  parameter int TIMEOUT    = 65535,
  localparam int PADDRW    = $clog2(PROG_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [PADDRW:0]   PROG_LEN,
  input  logic [CNTW-1:0]   EXP_RESULTS,
  input  logic              prog_wr_en,
  input  logic [PADDRW-1:0] prog_wr_addr,
  input  logic [TDATAW-1:0] prog_wr_data,
  input  logic [TDESTW-1:0] prog_wr_dest,
  input  logic              prog_wr_last,
  output logic              tx_tvalid,
  output logic [TDATAW-1:0] tx_tdata,
  output logic [TDESTW-1:0] tx_tdest,
  output logic              tx_tlast,
  input  logic              tx_tready,
  input  logic              rx_tvalid,
  input  logic [TDATAW-1:0] rx_tdata,
  input  logic [TDESTW-1:0] rx_tdest,
  input  logic              rx_tlast,
  output logic              rx_tready,
  output logic              DONE,
  output logic              ERR,
  output logic [TDATAW-1:0] IDATA_O1,
  output logic [TDATAW-1:0] IDATA_O2,
  output logic [TDATAW-1:0] ODATA_O
);

  localparam int TOW = $clog2(TIMEOUT + 1);

  drv_state_t        state_reg, state_next;
  logic [PADDRW:0]   len_reg, issue_reg, sent_reg;
  logic [CNTW-1:0]   exp_reg, res_cnt_reg;
  logic [TOW-1:0]    wait_reg;
  logic              done_reg, err_reg;
  logic              rd_valid_reg;
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        fifo_cnt_reg;
  logic [TDATAW-1:0] idata1_reg, idata2_reg, odata_reg;

  logic        idle_like, start_acc, tx_fire, rx_fire, last_flit, rd_en, ram_wr_en;
  logic [2:0]  occ;
  prog_entry_t wr_entry, rd_entry, head_entry;
  logic        unused_rx;

  assign unused_rx = ^{rx_tdest, rx_tlast};

  assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign start_acc = START && idle_like;
  assign ram_wr_en = prog_wr_en && idle_like;

  assign tx_tvalid = (fifo_cnt_reg != 2'd0);
  assign tx_fire   = tx_tvalid && tx_tready;
  assign rx_tready = (state_reg == ST_SEND) || (state_reg == ST_WAIT);
  assign rx_fire   = rx_tvalid && rx_tready;
  assign last_flit = tx_fire && (sent_reg == len_reg - 1'b1);

  // Only issue a read if the skid buffer is guaranteed a free slot when the
  // data lands two edges later, even if the sink stalls meanwhile.
  assign occ   = {1'b0, fifo_cnt_reg} + {2'b00, rd_valid_reg} - {2'b00, tx_fire};
  assign rd_en = (state_reg == ST_SEND) && (issue_reg < len_reg) && (occ < 3'd2);

  assign wr_entry = '{last: prog_wr_last, dest: prog_wr_dest, data: prog_wr_data};

  mvm_prog_ram #(.DEPTH(PROG_DEPTH)) u_prog_ram (
    .clk     (CLK),
    .wr_en   (ram_wr_en),
    .wr_addr (prog_wr_addr),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (issue_reg[PADDRW-1:0]),
    .rd_data (rd_entry)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    prog_entry_t slot_reg;
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        slot_reg <= '0;
      end else if (rd_valid_reg && (wr_ptr_reg == 1'(gi))) begin
        slot_reg <= rd_entry;
      end
    end
  end

  assign head_entry = rd_ptr_reg ? g_skid[1].slot_reg : g_skid[0].slot_reg;
  assign tx_tdata   = head_entry.data;
  assign tx_tdest   = head_entry.dest;
  assign tx_tlast   = head_entry.last;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_acc) state_next = (PROG_LEN == '0) ? ST_WAIT : ST_SEND;
      end
      ST_SEND: begin
        if (last_flit) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (res_cnt_reg == exp_reg || wait_reg == TOW'(TIMEOUT - 1)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      issue_reg    <= '0;
      sent_reg     <= '0;
      exp_reg      <= '0;
      res_cnt_reg  <= '0;
      wait_reg     <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
      idata1_reg   <= '0;
      idata2_reg   <= '0;
      odata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= rd_en;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, rd_valid_reg} - {1'b0, tx_fire};
      if (rd_valid_reg) wr_ptr_reg <= ~wr_ptr_reg;
      if (tx_fire)      rd_ptr_reg <= ~rd_ptr_reg;

      if (start_acc) begin
        len_reg     <= PROG_LEN;
        exp_reg     <= EXP_RESULTS;
        issue_reg   <= '0;
        sent_reg    <= '0;
        res_cnt_reg <= '0;
        wait_reg    <= '0;
        done_reg    <= 1'b0;
        err_reg     <= 1'b0;
        odata_reg   <= '0;
      end else begin
        if (rd_en) issue_reg <= issue_reg + 1'b1;
        if (tx_fire) begin
          sent_reg <= sent_reg + 1'b1;
          if (sent_reg == '0)              idata1_reg <= head_entry.data;
          if (sent_reg == (PADDRW+1)'(1))  idata2_reg <= head_entry.data;
        end
        if (rx_fire) begin
          odata_reg <= rx_tdata;
          if (res_cnt_reg != '1) res_cnt_reg <= res_cnt_reg + 1'b1;
        end
        if (state_reg == ST_WAIT) begin
          if (state_next == ST_DONE) begin
            done_reg <= 1'b1;
            err_reg  <= (res_cnt_reg != exp_reg);
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
      end
    end
  end

  assign DONE     = done_reg;
  assign ERR      = err_reg;
  assign IDATA_O1 = idata1_reg;
  assign IDATA_O2 = idata2_reg;
  assign ODATA_O  = odata_reg;

endmodule

// File: doc/mvm_stream_driver.md
# mvm_stream_driver

Single-node AXI-Stream traffic driver and result collector for the MVM mesh. On `START` it streams a preloaded program of flits (instructions, vectors, matrix rows) into a NoC injection port, so it sits directly upstream of the `rtl_mvm` tiles. It then counts result flits returned on the matching ejection port and raises `DONE`. It also exposes the first two injected words and the last result word for on-board observation.

## Interface
- `TDATAW`, default 512: flit data width (shared package value).
- `TDESTW`, default 4: flit destination width (shared package value).
- `PROG_DEPTH`, default 64: program memory entries; `PADDRW = $clog2(PROG_DEPTH)`.
- `CNTW`, default 16: width of the result counter.
- `TIMEOUT`, default 65535: maximum cycles spent in WAIT before an error abort.

Ports:
- `CLK`, in, 1: single clock.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `START`, in, 1: run request, sampled in IDLE or DONE_ST only.
- `PROG_LEN`, in, PADDRW+1: flits to send (0..PROG_DEPTH), latched on accepted `START`.
- `EXP_RESULTS`, in, CNTW: result flits to await, latched on accepted `START`.
- `prog_wr_en`, in, 1: program write strobe, honoured in IDLE/DONE_ST only.
- `prog_wr_addr`, in, PADDRW: program write address.
- `prog_wr_data`, in, TDATAW: data field of the program entry.
- `prog_wr_dest`, in, TDESTW: destination field of the program entry.
- `prog_wr_last`, in, 1: last field of the program entry.
- `tx_tvalid`, out, 1; `tx_tdata`, out, TDATAW; `tx_tdest`, out, TDESTW; `tx_tlast`, out, 1: injection stream toward the NoC.
- `tx_tready`, in, 1: injection backpressure.
- `rx_tvalid`, in, 1; `rx_tdata`, in, TDATAW; `rx_tdest`, in, TDESTW; `rx_tlast`, in, 1: ejection stream from the NoC.
- `rx_tready`, out, 1: ejection ready.
- `DONE`, out, 1: sticky completion flag.
- `ERR`, out, 1: sticky timeout flag.
- `IDATA_O1`, out, TDATAW: tdata of transmitted flit 0.
- `IDATA_O2`, out, TDATAW: tdata of transmitted flit 1.
- `ODATA_O`, out, TDATAW: tdata of the most recent accepted result flit.

## Operation
- **Reset values:** all outputs are 0 on reset, including `tx_tvalid`, `rx_tready`, `DONE`, `ERR` and all three data outputs. State is IDLE. Program memory contents are not reset.
- **States:** IDLE → SEND → WAIT → DONE_ST.
  - An accepted `START` latches `PROG_LEN` and `EXP_RESULTS`, clears `DONE`, `ERR`, `ODATA_O` and the counters, then enters SEND.
  - If `PROG_LEN`=0, the driver skips directly to WAIT.
  - SEND emits entries 0..PROG_LEN-1 in address order. The handshake on entry PROG_LEN-1 moves the state to WAIT.
  - In WAIT, the driver goes to DONE_ST when the result count equals `EXP_RESULTS`. With `EXP_RESULTS`=0 this happens on the cycle after entering WAIT.
  - If WAIT reaches `TIMEOUT` cycles, the driver goes to DONE_ST with `ERR`=1.
  - `START` in DONE_ST re-runs exactly as from IDLE.
  - `START` in SEND or WAIT is ignored.
- **TX rules:**
  - AXI-S semantics apply: once `tx_tvalid` is high, it and the tdata/tdest/tlast payload stay stable until `tx_tready` is sampled high.
  - `tx_tlast` comes from the stored entry, not from position in the program.
- **Capture:** `IDATA_O1` and `IDATA_O2` update on the handshakes of flits 0 and 1. Both hold their values across runs unless overwritten.
- **RX rules:**
  - `rx_tready` is 1 in SEND and WAIT, and 0 in IDLE and DONE_ST.
  - Each rx handshake increments the result count and loads `ODATA_O`.
  - `rx_tdest` and `rx_tlast` are ignored.
  - Results arriving during SEND count toward `EXP_RESULTS`.
  - The counter saturates at its maximum value.
- **Program writes:** writes arriving in SEND or WAIT are dropped.
- **Reset mid-run:** `tx_tvalid` is abandoned immediately with no flit completion. Asserting `RST_N` low is the only abort mechanism.

## Timing
- `START` is sampled at edge 0. `tx_tvalid` rises after edge 2 (the synchronous RAM read costs 1 cycle).
- With `tx_tready` held high, the driver sustains 1 flit per cycle with no bubbles. A 2-entry output skid buffer absorbs the RAM latency.
- `DONE` rises on the edge after the final counted rx handshake.
- `ERR` and `DONE` rise together on timeout.

## Structure
- **Shared package:** add the state enum `drv_state_t` and the packed struct `prog_entry_t` {last, dest, data} to the shared parameters package.
- **Sub-module:** `mvm_prog_ram`, a simple dual-port synchronous RAM holding `prog_entry_t` words with 1-cycle read latency.

## Test plan
- **Basic run:** program 4 entries with data 0x11..0x44, dest 1, and last set only on entry 3. Apply START with `PROG_LEN`=4 and `EXP_RESULTS`=2; keep tready at 1 and return 2 flits (0xA, 0xB). Required: 4 consecutive flits, `IDATA_O1`=0x11, `IDATA_O2`=0x22, `ODATA_O`=0xB, `DONE`=1, `ERR`=0.
- **Backpressure:** same program with tready toggling 1010. Required: no payload change while stalled, and all 4 flits delivered in order.
- **Zero lengths:** `PROG_LEN`=0 with `EXP_RESULTS`=0. Required: no tx activity, and `DONE`=1 within 3 cycles.
- **Timeout:** `TIMEOUT`=20 and `EXP_RESULTS`=3, with only 1 result returned. Required: `DONE`=1 and `ERR`=1 after 20 WAIT cycles, and `ODATA_O` equals the single result.
- **Ignored inputs:** assert START and `prog_wr_en` mid-SEND. Required: the run is unaffected and the program RAM is unchanged.
- **Reset mid-run:** assert reset during SEND with tready=0. Required: all outputs return to 0 asynchronously, and a fresh START after reset performs a correct run.
